// File: rtl/stopwatch.sv
// BCD stopwatch: counts milliseconds up to 9:59:59.999 with start/stop and clear buttons.
module stopwatch #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       STOPWATCH_RUN,
    input  logic       SW_F1,
    input  logic       SW_F2,
    output logic [3:0] MSE00,
    output logic [3:0] MSEC1ST,
    output logic [3:0] MSEC2ND,
    output logic [3:0] SECLOW,
    output logic [2:0] SECHIGH,
    output logic [3:0] MINLOW,
    output logic [2:0] MINHIGH,
    output logic [3:0] HOUR
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          f1_q, f2_q;
    logic [PW-1:0] presc_q, presc_d;

    logic [3:0] ms0_q, ms0_d;
    logic [3:0] ms1_q, ms1_d;
    logic [3:0] ms2_q, ms2_d;
    logic [3:0] sl_q,  sl_d;
    logic [2:0] sh_q,  sh_d;
    logic [3:0] ml_q,  ml_d;
    logic [2:0] mh_q,  mh_d;
    logic [3:0] hr_q,  hr_d;

    logic       f1_rise_c, f2_rise_c;
    logic       toggle_c, clear_c, count_c, tick_c;
    logic [7:0] carry_c;

    // Button edges, qualified by mode; start/stop wins over clear, and the stopping cycle does not count.
    always_comb begin
        f1_rise_c = SW_F1 & ~f1_q;
        f2_rise_c = SW_F2 & ~f2_q;
        toggle_c  = f1_rise_c & STOPWATCH_RUN;
        clear_c   = f2_rise_c & STOPWATCH_RUN & ~toggle_c & (state_q == ST_STOP);
        count_c   = (state_q == ST_RUN) & ~toggle_c;
        tick_c    = count_c & (presc_q == PRESC_MAX);
    end

    // Run/stop next-state logic.
    always_comb begin
        state_d = state_q;
        if (toggle_c) begin
            case (state_q)
                ST_STOP: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end
    end

    // Millisecond prescaler: wraps at TICK_DIV-1, held while stopped.
    always_comb begin
        presc_d = presc_q;
        if (clear_c) begin
            presc_d = '0;
        end else if (count_c) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end
    end

    // BCD cascade: each digit advances when every lower digit is at its maximum.
    always_comb begin
        ms0_d = ms0_q;
        ms1_d = ms1_q;
        ms2_d = ms2_q;
        sl_d  = sl_q;
        sh_d  = sh_q;
        ml_d  = ml_q;
        mh_d  = mh_q;
        hr_d  = hr_q;

        carry_c[0] = tick_c;
        carry_c[1] = carry_c[0] & (ms0_q == 4'd9);
        carry_c[2] = carry_c[1] & (ms1_q == 4'd9);
        carry_c[3] = carry_c[2] & (ms2_q == 4'd9);
        carry_c[4] = carry_c[3] & (sl_q  == 4'd9);
        carry_c[5] = carry_c[4] & (sh_q  == 3'd5);
        carry_c[6] = carry_c[5] & (ml_q  == 4'd9);
        carry_c[7] = carry_c[6] & (mh_q  == 3'd5);

        if (clear_c) begin
            ms0_d = '0;
            ms1_d = '0;
            ms2_d = '0;
            sl_d  = '0;
            sh_d  = '0;
            ml_d  = '0;
            mh_d  = '0;
            hr_d  = '0;
        end else begin
            if (carry_c[0]) ms0_d = (ms0_q == 4'd9) ? 4'd0 : ms0_q + 4'd1;
            if (carry_c[1]) ms1_d = (ms1_q == 4'd9) ? 4'd0 : ms1_q + 4'd1;
            if (carry_c[2]) ms2_d = (ms2_q == 4'd9) ? 4'd0 : ms2_q + 4'd1;
            if (carry_c[3]) sl_d  = (sl_q  == 4'd9) ? 4'd0 : sl_q  + 4'd1;
            if (carry_c[4]) sh_d  = (sh_q  == 3'd5) ? 3'd0 : sh_q  + 3'd1;
            if (carry_c[5]) ml_d  = (ml_q  == 4'd9) ? 4'd0 : ml_q  + 4'd1;
            if (carry_c[6]) mh_d  = (mh_q  == 3'd5) ? 3'd0 : mh_q  + 3'd1;
            if (carry_c[7]) hr_d  = (hr_q  == 4'd9) ? 4'd0 : hr_q  + 4'd1;
        end
    end

    // State, button history, prescaler and digit registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_STOP;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            presc_q <= '0;
            ms0_q   <= '0;
            ms1_q   <= '0;
            ms2_q   <= '0;
            sl_q    <= '0;
            sh_q    <= '0;
            ml_q    <= '0;
            mh_q    <= '0;
            hr_q    <= '0;
        end else begin
            state_q <= state_d;
            f1_q    <= SW_F1;
            f2_q    <= SW_F2;
            presc_q <= presc_d;
            ms0_q   <= ms0_d;
            ms1_q   <= ms1_d;
            ms2_q   <= ms2_d;
            sl_q    <= sl_d;
            sh_q    <= sh_d;
            ml_q    <= ml_d;
            mh_q    <= mh_d;
            hr_q    <= hr_d;
        end
    end

    assign MSE00   = ms0_q;
    assign MSEC1ST = ms1_q;
    assign MSEC2ND = ms2_q;
    assign SECLOW  = sl_q;
    assign SECHIGH = sh_q;
    assign MINLOW  = ml_q;
    assign MINHIGH = mh_q;
    assign HOUR    = hr_q;

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for the BCD stopwatch (TICK_DIV = 1).
module tb_stopwatch;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       STOPWATCH_RUN = 1'b0;
    logic       SW_F1 = 1'b0;
    logic       SW_F2 = 1'b0;
    logic [3:0] MSE00, MSEC1ST, MSEC2ND, SECLOW, MINLOW, HOUR;
    logic [2:0] SECHIGH, MINHIGH;

    stopwatch #(.TICK_DIV(1)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .STOPWATCH_RUN (STOPWATCH_RUN),
        .SW_F1         (SW_F1),
        .SW_F2         (SW_F2),
        .MSE00         (MSE00),
        .MSEC1ST       (MSEC1ST),
        .MSEC2ND       (MSEC2ND),
        .SECLOW        (SECLOW),
        .SECHIGH       (SECHIGH),
        .MINLOW        (MINLOW),
        .MINHIGH       (MINHIGH),
        .HOUR          (HOUR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;
        bit         mode;
        bit         f1;
        bit         f2;
        logic [3:0] ms1;
        logic [3:0] ms0;
        string      name;
    } vec_t;

    typedef struct {
        logic [29:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[32];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: total elapsed milliseconds plus run flag and button history.
    int m_cnt = 0;
    bit m_run = 1'b0;
    bit m_f1q = 1'b0;
    bit m_f2q = 1'b0;

    function automatic logic [29:0] pack_cnt(input int c);
        int ms, s, m, h;
        ms = c % 1000;
        s  = (c / 1000) % 60;
        m  = (c / 60000) % 60;
        h  = (c / 3600000) % 10;
        return {4'(h), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
                4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {HOUR, MINHIGH, MINLOW, SECHIGH, SECLOW, MSEC2ND, MSEC1ST, MSE00};
    endfunction

    task automatic model_step(input bit rst, input bit mode, input bit f1, input bit f2);
        bit r1, r2;
        if (!rst) begin
            m_cnt = 0;
            m_run = 1'b0;
            m_f1q = 1'b0;
            m_f2q = 1'b0;
        end else begin
            r1 = f1 & ~m_f1q & mode;
            r2 = f2 & ~m_f2q & mode;
            if (r1)         m_run = ~m_run;
            else if (m_run) m_cnt = (m_cnt + 1) % 36000000;
            else if (r2)    m_cnt = 0;
            m_f1q = f1;
            m_f2q = f2;
        end
    endtask

    // Apply one cycle of inputs, queue the expectation, then check after the edge.
    task automatic drive(input bit rst, input bit mode, input bit f1, input bit f2,
                         input logic [29:0] exp, input string name);
        sb_t         e;
        logic [29:0] act;
        @(negedge CLK);
        RST           = rst;
        STOPWATCH_RUN = mode;
        SW_F1         = f1;
        SW_F2         = f2;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, dut_vec());
        end else begin
            e   = sb_q.pop_front();
            act = dut_vec();
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic mdrive(input bit rst, input bit mode, input bit f1, input bit f2,
                          input string name);
        model_step(rst, mode, f1, f2);
        drive(rst, mode, f1, f2, pack_cnt(m_cnt), name);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, "reset0"};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, "reset1"};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, "idle"};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, "start_edge"};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, "held_f1"};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, "count2"};
        for (int k = 0; k < 7; k++)
            tbl[6+k] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(3 + k), "count"};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, "carry_10ms"};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, "count11"};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1, "stop_edge"};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, "frozen"};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, "clear"};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, "cleared"};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, "gated_f1"};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, "gated_idle"};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, "gated_f2"};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, "gated_idle2"};
        tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, "restart"};
        tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, "run1"};
        tbl[25] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, "clear_running"};
        tbl[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, "run3"};
        tbl[27] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, "bg_run"};
        tbl[28] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, "bg_f1_ignored"};
        tbl[29] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd6, "bg_run2"};
        tbl[30] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd6, "stop2"};
        tbl[31] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, "frozen2"};

        for (int i = 0; i < 32; i++) begin
            model_step(tbl[i].rst, tbl[i].mode, tbl[i].f1, tbl[i].f2);
            drive(tbl[i].rst, tbl[i].mode, tbl[i].f1, tbl[i].f2,
                  {22'd0, tbl[i].ms1, tbl[i].ms0}, tbl[i].name);
        end

        // Simultaneous start and clear while stopped at a nonzero value.
        mdrive(1'b1, 1'b1, 1'b1, 1'b1, "f1f2_same");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "after_f1f2");

        // Reset while running.
        mdrive(1'b0, 1'b1, 1'b0, 1'b0, "rst_midrun");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "rst_stopped");

        // Preload 0:59:59.999 while stopped, then start and carry into the hour.
        force dut.ms0_q = 4'd9;
        force dut.ms1_q = 4'd9;
        force dut.ms2_q = 4'd9;
        force dut.sl_q  = 4'd9;
        force dut.sh_q  = 3'd5;
        force dut.ml_q  = 4'd9;
        force dut.mh_q  = 3'd5;
        force dut.hr_q  = 4'd0;
        m_cnt = 3599999;
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "preload_059");
        release dut.ms0_q;
        release dut.ms1_q;
        release dut.ms2_q;
        release dut.sl_q;
        release dut.sh_q;
        release dut.ml_q;
        release dut.mh_q;
        release dut.hr_q;
        mdrive(1'b1, 1'b1, 1'b1, 1'b0, "start_059");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "hour_carry");
        mdrive(1'b1, 1'b1, 1'b1, 1'b0, "stop_1h");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "held_1h");

        // Preload 9:59:59.999, then the full wrap to zero while staying in run.
        force dut.ms0_q = 4'd9;
        force dut.ms1_q = 4'd9;
        force dut.ms2_q = 4'd9;
        force dut.sl_q  = 4'd9;
        force dut.sh_q  = 3'd5;
        force dut.ml_q  = 4'd9;
        force dut.mh_q  = 3'd5;
        force dut.hr_q  = 4'd9;
        m_cnt = 35999999;
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "preload_959");
        release dut.ms0_q;
        release dut.ms1_q;
        release dut.ms2_q;
        release dut.sl_q;
        release dut.sh_q;
        release dut.ml_q;
        release dut.mh_q;
        release dut.hr_q;
        mdrive(1'b1, 1'b1, 1'b1, 1'b0, "start_959");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "full_wrap");
        mdrive(1'b1, 1'b1, 1'b0, 1'b0, "run_after_wrap");

        // Random button and mode activity against the model.
        for (int i = 0; i < 200; i++) begin
            mdrive(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch.md
Name: stopwatch

Overview:
- BCD stopwatch for the digital clock module: counts milliseconds up to 9:59:59.999 and shows each digit on its own output bus.
- Two push-buttons control it: SW_F1 starts and stops; SW_F2 clears while stopped.
- STOPWATCH_RUN is the mode-select from the clock's top-level controller. It gates button handling.

Parameters:
- TICK_DIV, default 1: number of CLK cycles per 1 ms count. Use 1 for simulation and the clock frequency divided by 1000 in silicon. Minimum value is 1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-low. Clears all state while low at a rising CLK edge.
- STOPWATCH_RUN  in  1  stopwatch mode selected. Buttons are honoured only when this is 1.
- SW_F1  in  1  start/stop button, level input, held for one or more cycles.
- SW_F2  in  1  clear button, level input.
- MSE00  out  4  1 ms digit, 0-9.
- MSEC1ST  out  4  10 ms digit, 0-9.
- MSEC2ND  out  4  100 ms digit, 0-9.
- SECLOW  out  4  seconds units, 0-9.
- SECHIGH  out  3  seconds tens, 0-5.
- MINLOW  out  4  minutes units, 0-9.
- MINHIGH  out  3  minutes tens, 0-5.
- HOUR  out  4  hours, 0-9.

Behaviour:
- Reset (RST=0 at a rising edge):
  - All digit outputs become 0.
  - Internal run flag becomes 0 (stopped).
  - Prescaler becomes 0.
  - Button history registers f1_q and f2_q become 0.
  - Reset has priority over every other event.
- Button edge detection:
  - f1_q and f2_q register SW_F1 and SW_F2 every cycle.
  - Start/stop edge: f1_rise = SW_F1 & ~f1_q.
  - Clear edge: f2_rise = SW_F2 & ~f2_q.
  - Holding a button produces exactly one event.
  - The history registers update regardless of STOPWATCH_RUN.
- Run/stop:
  - On a cycle where f1_rise=1 and STOPWATCH_RUN=1, the run flag toggles.
- Clear:
  - On a cycle where f2_rise=1, STOPWATCH_RUN=1 and run=0, all digits and the prescaler go to 0.
  - f2_rise while running is ignored.
  - If f1_rise and f2_rise occur in the same cycle, only the run toggle is applied; clear is ignored.
- STOPWATCH_RUN=0:
  - Button edges are discarded.
  - The run flag and counting are unaffected, so a running stopwatch keeps counting in the background.
- Prescaler (only while run=1):
  - Increments each cycle.
  - When it reaches TICK_DIV-1 it wraps to 0 and asserts a one-cycle tick.
  - With TICK_DIV=1, every run cycle is a tick.
- Count cascade on tick (registered):
  - MSE00 increments; at 9 it wraps to 0 and carries into MSEC1ST.
  - MSEC1ST 0-9 carries into MSEC2ND; MSEC2ND 0-9 carries into SECLOW.
  - SECLOW 0-9 carries into SECHIGH; SECHIGH 0-5 carries into MINLOW.
  - MINLOW 0-9 carries into MINHIGH; MINHIGH 0-5 carries into HOUR.
  - HOUR 0-9 wraps to 0.
  - 9:59:59.999 plus one tick gives 0:00:00.000, all digits in the same cycle. The run flag is unchanged.
- Latency and freeze:
  - The run flag is set on the edge that samples f1_rise; the first tick comes from the following edge.
  - With TICK_DIV=1, MSE00=1 appears two rising edges after SW_F1 is first sampled high.
  - On stop, digits freeze at the value they hold after the stopping edge; no increment happens on that edge.
- Outputs are driven directly from registers, with no combinational path from inputs.

Test Plan:
- Reset: set RST=0 for 2 cycles with random inputs -> all digits 0; SW_F1 pulses are then needed to count.
- Start and count (TICK_DIV=1, STOPWATCH_RUN=1): raise SW_F1 for 2 cycles -> MSE00 goes 1,2,3… from the second edge after the press; after 10 ticks MSE00=0 and MSEC1ST=1; held button gives a single start.
- Stop and clear:
  - Pulse SW_F1 after 11 ticks -> digits freeze at MSEC1ST=1, MSE00=1.
  - Pulse SW_F2 -> all digits 0.
  - Pulse SW_F2 while running -> no effect.
- Mode gating:
  - With STOPWATCH_RUN=0, SW_F1/SW_F2 pulses -> no start, stop or clear.
  - Running then STOPWATCH_RUN=0 -> counting continues.
- Cascade and wrap: force or preload to 0:59:59.999 then tick -> 1:00:00.000 (HOUR=1). From 9:59:59.999 -> all 0, still running.
- Simultaneous events and reset mid-run:
  - Stopped with a nonzero value, F1 and F2 rise in the same cycle -> starts counting from the held value, no clear.
  - RST=0 while running -> digits 0 and stopped next edge.
